lfsr_decrypt: RTL

//  Receive-side counterpart of the Lab 4 LFSR scrambler. Reads the 64-byte encrypted block
//  (preamble of '_' + message, each byte XORed with {2'b00,LFSR}) from data memory.

---
 rtl/lfsr_dec_pkg.sv | 25 ++
 rtl/lfsr6.sv | 27 ++
 rtl/lfsr_decrypt.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lfsr_dec_pkg.sv
// Shared types and constants for the LFSR block decryptor.
// Tap candidates are tried in list order; also used by encrypt-side benches.
package lfsr_dec_pkg;

  typedef enum logic [2:0] {SEED, TRY, DECODE, DONE, FAIL} state_t;

  localparam int NUM_TAPS = 6;
  localparam logic [5:0] TAP_LIST [NUM_TAPS] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  localparam logic [7:0] MSG_BASE  = 8'd64;
  localparam logic [7:0] MSG_LEN   = 8'd64;
  localparam logic [7:0] OUT_BASE  = 8'd0;
  localparam logic [7:0] PRE_CHAR  = 8'h5F;
  localparam logic [7:0] CHECK_LEN = 8'd7;

  // Out-of-range candidate indices fall back to the first entry.
  function automatic logic [5:0] tap_sel(input logic [2:0] c);
    logic [5:0] t;
    t = TAP_LIST[0];
    for (int k = 0; k < NUM_TAPS; k++)
      if (c == 3'(k)) t = TAP_LIST[k];
    return t;
  endfunction

endpackage

// File: rtl/lfsr6.sv
// 6-bit Fibonacci LFSR with loadable start state and tap pattern.
// init has priority over en; next = {s[4:0], ^(s & taps)}.
module lfsr6 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       init,
  input  logic [5:0] taps,
  input  logic [5:0] start,
  output logic [5:0] state
);

  logic [5:0] taps_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= 6'd0;
      taps_q <= 6'd0;
    end else if (init) begin
      state  <= start;
      taps_q <= taps;
    end else if (en) begin
      state  <= {state[4:0], ^(state & taps_q)};
    end
  end

endmodule

// File: rtl/lfsr_decrypt.sv
// Receive-side LFSR decryptor: recovers seed and taps from the preamble, then
// writes plaintext. Define LFSR_DEC_STATUS_EN to expose found_taps/found_prelen.
module lfsr_decrypt
  import lfsr_dec_pkg::*;
(
  input  logic       clk,
  input  logic       init,
  output logic [7:0] mem_raddr,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_waddr,
  output logic [7:0] mem_wdata,
`ifdef LFSR_DEC_STATUS_EN
  output logic [5:0] found_taps,
  output logic [7:0] found_prelen,
`endif
  output logic       done,
  output logic       err
);

  state_t     state, state_d;
  logic       load, load_d;
  logic [2:0] cand, cand_d;
  logic [7:0] i, i_d;
  logic [7:0] j, j_d;
  logic [7:0] pre_len, pre_len_d;
  logic       skip, skip_d;
  logic [5:0] start, start_d;
  logic [5:0] key;
  logic [7:0] plain;
  logic       lfsr_load, lfsr_adv;

  lfsr6 u_lfsr (
    .clk   (clk),
    .rst   (init),
    .en    (lfsr_adv),
    .init  (lfsr_load),
    .taps  (tap_sel(cand)),
    .start (start),
    .state (key)
  );

  assign plain     = mem_rdata ^ {2'b00, key};
  assign lfsr_load = (state == TRY || state == DECODE) && load;
  assign lfsr_adv  = (state == TRY || state == DECODE) && !load;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state   <= SEED;
      load    <= 1'b0;
      cand    <= 3'd0;
      i       <= 8'd0;
      j       <= 8'd0;
      pre_len <= 8'd0;
      skip    <= 1'b0;
      start   <= 6'd0;
    end else begin
      state   <= state_d;
      load    <= load_d;
      cand    <= cand_d;
      i       <= i_d;
      j       <= j_d;
      pre_len <= pre_len_d;
      skip    <= skip_d;
      start   <= start_d;
    end
  end

  always_comb begin
    state_d   = state;
    load_d    = load;
    cand_d    = cand;
    i_d       = i;
    j_d       = j;
    pre_len_d = pre_len;
    skip_d    = skip;
    start_d   = start;
    mem_raddr = MSG_BASE + i;
    mem_we    = 1'b0;
    mem_waddr = 8'd0;
    mem_wdata = 8'd0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      SEED: begin
        mem_raddr = MSG_BASE;
        start_d   = mem_rdata[5:0] ^ PRE_CHAR[5:0];
        state_d   = TRY;
        load_d    = 1'b1;
        cand_d    = 3'd0;
        i_d       = 8'd0;
      end
      TRY: begin
        if (load) begin
          load_d = 1'b0;
          i_d    = 8'd0;
        end else if (plain == PRE_CHAR) begin
          if (i == CHECK_LEN - 8'd1) begin
            state_d = DECODE;
            load_d  = 1'b1;
            i_d     = 8'd0;
          end else begin
            i_d = i + 8'd1;
          end
        end else if (cand == 3'(NUM_TAPS - 1)) begin
          state_d = FAIL;
        end else begin
          cand_d = cand + 3'd1;
          load_d = 1'b1;
          i_d    = 8'd0;
        end
      end
      DECODE: begin
        if (load) begin
          load_d    = 1'b0;
          i_d       = 8'd0;
          j_d       = 8'd0;
          pre_len_d = 8'd0;
          skip_d    = 1'b1;
        end else begin
          // Skipping ends at the first non-preamble byte and never restarts.
          if (skip && plain == PRE_CHAR) begin
            pre_len_d = pre_len + 8'd1;
          end else begin
            skip_d    = 1'b0;
            mem_we    = 1'b1;
            mem_waddr = OUT_BASE + j;
            mem_wdata = plain;
            j_d       = j + 8'd1;
          end
          if (i == MSG_LEN - 8'd1) state_d = DONE;
          else                     i_d     = i + 8'd1;
        end
      end
      DONE: done = 1'b1;
      FAIL: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: state_d = SEED;
    endcase
  end

`ifdef LFSR_DEC_STATUS_EN
  assign found_taps   = (state == DONE) ? tap_sel(cand) : 6'd0;
  assign found_prelen = (state == DONE) ? pre_len : 8'd0;
`endif

endmodule
